i2c_passthru_rxtx_ctrl_mc: RTL and testbench

- Bit-level direction and handshake controller for the I2C passthrough, fanned out to NUM_SLV downstream buses.
- Tracks START, STOP, bit count, R/W and ACK on the upstream master bus (channel A) and on one selected downstream bus (channel B[sel]).
- Sequences the rx/tx bit engines via o_start and o_tx_to_mst.
- Adds downstream bus select, STOP-to-idle, a stall timeout and status outputs.

---
 rtl/i2c_passthru_pkg.sv | 16 +
 rtl/i2c_passthru_cond_det.sv | 22 ++
 rtl/i2c_passthru_rxtx_ctrl_mc.sv | 164 ++++++++++++++++
 tb/tb_i2c_passthru_rxtx_ctrl_mc.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/i2c_passthru_pkg.sv
// Shared types and bit positions for the I2C passthrough direction controller.
package i2c_passthru_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MST_RX_WAIT,
        MST_RX_START,
        SLV_RX_WAIT,
        SLV_RX_START
    } state_t;

    // Bit counter value while the R/W bit is on the wire (first byte) and the ACK slot.
    localparam logic [3:0] BIT_RW_ACKPOS = 4'd8;
    localparam logic [3:0] BIT_ACK       = 4'd9;

endpackage

// File: rtl/i2c_passthru_cond_det.sv
// START/STOP detector for one synchronised SCL/SDA pair.
module i2c_passthru_cond_det (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_start,
    output logic o_stop
);

    logic prev_sda;

    // Keep last SDA sample; resets high so an idle bus never looks like an edge.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) prev_sda <= 1'b1;
        else         prev_sda <= i_sda;
    end

    assign o_start = i_scl &  prev_sda & ~i_sda;
    assign o_stop  = i_scl & ~prev_sda &  i_sda;

endmodule

// File: rtl/i2c_passthru_rxtx_ctrl_mc.sv
// Bit-level direction/handshake controller for the I2C passthrough, one master
// bus fanned out to NUM_SLV downstream buses.
module i2c_passthru_rxtx_ctrl_mc
    import i2c_passthru_pkg::*;
#(
    parameter int NUM_SLV     = 2,
    parameter int SEL_W       = 1,
    parameter int TO_W        = 16,
    parameter int TIMEOUT_CYC = 50000,
    parameter int BCNT_W      = 8
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_cha_scl,
    input  logic               i_cha_sda,
    input  logic [NUM_SLV-1:0] i_chb_scl,
    input  logic [NUM_SLV-1:0] i_chb_sda,
    input  logic [SEL_W-1:0]   i_slv_sel,
    input  logic               i_rx_done,
    input  logic               i_tx_done,
    input  logic               i_rx_sda_init_valid,
    input  logic               i_rx_sda_init,
    output logic               o_start,
    output logic               o_tx_to_mst,
    output logic [NUM_SLV-1:0] o_chb_en,
    output logic               o_busy,
    output logic               o_read_mode,
    output logic               o_ack_failed,
    output logic [BCNT_W-1:0]  o_byte_cnt,
    output logic               o_timeout
);

    state_t             state;
    logic [3:0]         bit_cnt;
    logic               first_byte;
    logic [SEL_W-1:0]   sel;
    logic [TO_W-1:0]    to_cnt;

    logic               cha_start, cha_stop;
    logic [NUM_SLV-1:0] chb_start, chb_stop;
    logic               chb_start_sel, chb_stop_sel;
    logic [NUM_SLV-1:0] chb_en_nxt;
    logic               start_ev, stop_ev, in_wait, dir_next, to_hit;

    i2c_passthru_cond_det u_cha (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_scl   (i_cha_scl),
        .i_sda   (i_cha_sda),
        .o_start (cha_start),
        .o_stop  (cha_stop)
    );

    for (genvar g = 0; g < NUM_SLV; g++) begin : g_chb
        i2c_passthru_cond_det u_chb (
            .i_clk   (i_clk),
            .i_rstn  (i_rstn),
            .i_scl   (i_chb_scl[g]),
            .i_sda   (i_chb_sda[g]),
            .o_start (chb_start[g]),
            .o_stop  (chb_stop[g])
        );
    end

    // Pick the selected downstream bus's conditions; out-of-range sel selects nothing.
    always_comb begin
        chb_start_sel = 1'b0;
        chb_stop_sel  = 1'b0;
        chb_en_nxt    = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (sel == SEL_W'(i)) begin
                chb_start_sel = chb_start[i];
                chb_stop_sel  = chb_stop[i];
            end
            chb_en_nxt[i] = (i_slv_sel == SEL_W'(i));
        end
    end

    assign start_ev = cha_start | (o_busy & chb_start_sel);
    assign stop_ev  = cha_stop  | (o_busy & chb_stop_sel);
    assign in_wait  = (state == MST_RX_WAIT) || (state == SLV_RX_WAIT);

    // Direction of the next bit: the address ACK always comes from the slave,
    // later ACKs come from whoever did not send the data byte.
    assign dir_next = (bit_cnt == BIT_RW_ACKPOS) ? (first_byte | ~o_read_mode)
                                                 : (o_read_mode & ~o_ack_failed);

    assign to_hit = (TIMEOUT_CYC != 0) && in_wait && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

    // Main sequencer: bus events first, then stall abort, then bit handshake.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            first_byte   <= 1'b0;
            sel          <= '0;
            to_cnt       <= '0;
            o_start      <= 1'b0;
            o_tx_to_mst  <= 1'b0;
            o_chb_en     <= '0;
            o_busy       <= 1'b0;
            o_read_mode  <= 1'b0;
            o_ack_failed <= 1'b0;
            o_byte_cnt   <= '0;
            o_timeout    <= 1'b0;
        end else begin
            o_start   <= 1'b0;
            o_timeout <= 1'b0;
            if (start_ev) begin
                state        <= MST_RX_WAIT;
                bit_cnt      <= '0;
                o_byte_cnt   <= '0;
                o_read_mode  <= 1'b0;
                o_ack_failed <= 1'b0;
                first_byte   <= 1'b1;
                sel          <= i_slv_sel;
                o_busy       <= 1'b1;
                o_chb_en     <= chb_en_nxt;
                o_tx_to_mst  <= 1'b0;
                to_cnt       <= '0;
            end else if (stop_ev) begin
                state       <= IDLE;
                o_busy      <= 1'b0;
                o_chb_en    <= '0;
                o_tx_to_mst <= 1'b0;
            end else if (to_hit) begin
                state       <= IDLE;
                o_busy      <= 1'b0;
                o_chb_en    <= '0;
                o_tx_to_mst <= 1'b0;
                o_timeout   <= 1'b1;
            end else begin
                if (state != IDLE && i_rx_sda_init_valid) begin
                    if (bit_cnt == BIT_RW_ACKPOS && first_byte) o_read_mode <= i_rx_sda_init;
                    if (bit_cnt == BIT_ACK && i_rx_sda_init)    o_ack_failed <= 1'b1;
                end
                case (state)
                    MST_RX_WAIT, SLV_RX_WAIT: begin
                        if (i_rx_done && i_tx_done) begin
                            state       <= dir_next ? SLV_RX_START : MST_RX_START;
                            o_start     <= 1'b1;
                            o_tx_to_mst <= dir_next;
                        end else if (to_cnt != '1) begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                    MST_RX_START, SLV_RX_START: begin
                        state  <= (state == SLV_RX_START) ? SLV_RX_WAIT : MST_RX_WAIT;
                        to_cnt <= '0;
                        if (bit_cnt == BIT_ACK) begin
                            bit_cnt    <= 4'd1;
                            first_byte <= 1'b0;
                            if (o_byte_cnt != '1) o_byte_cnt <= o_byte_cnt + 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_passthru_rxtx_ctrl_mc.sv
// Directed bench for the I2C passthrough direction controller.
module tb_i2c_passthru_rxtx_ctrl_mc;

    localparam int NUM_SLV     = 2;
    localparam int SEL_W       = 1;
    localparam int TO_W        = 16;
    localparam int TIMEOUT_CYC = 20;
    localparam int BCNT_W      = 8;

    logic               i_clk = 1'b0;
    logic               i_rstn = 1'b0;
    logic               i_cha_scl = 1'b1, i_cha_sda = 1'b1;
    logic [NUM_SLV-1:0] i_chb_scl = '1, i_chb_sda = '1;
    logic [SEL_W-1:0]   i_slv_sel = '0;
    logic               i_rx_done = 1'b0, i_tx_done = 1'b0;
    logic               i_rx_sda_init_valid = 1'b0, i_rx_sda_init = 1'b0;
    logic               o_start, o_tx_to_mst, o_busy, o_read_mode, o_ack_failed, o_timeout;
    logic [NUM_SLV-1:0] o_chb_en;
    logic [BCNT_W-1:0]  o_byte_cnt;

    int checks = 0;
    int errors = 0;

    i2c_passthru_rxtx_ctrl_mc #(
        .NUM_SLV(NUM_SLV), .SEL_W(SEL_W), .TO_W(TO_W),
        .TIMEOUT_CYC(TIMEOUT_CYC), .BCNT_W(BCNT_W)
    ) dut (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .i_cha_scl(i_cha_scl), .i_cha_sda(i_cha_sda),
        .i_chb_scl(i_chb_scl), .i_chb_sda(i_chb_sda),
        .i_slv_sel(i_slv_sel),
        .i_rx_done(i_rx_done), .i_tx_done(i_tx_done),
        .i_rx_sda_init_valid(i_rx_sda_init_valid), .i_rx_sda_init(i_rx_sda_init),
        .o_start(o_start), .o_tx_to_mst(o_tx_to_mst), .o_chb_en(o_chb_en),
        .o_busy(o_busy), .o_read_mode(o_read_mode), .o_ack_failed(o_ack_failed),
        .o_byte_cnt(o_byte_cnt), .o_timeout(o_timeout)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // START on channel A; checks the state established by the START edge.
    task automatic bus_start(input logic [1:0] exp_en, input string tag);
        i_cha_sda = 1'b1; step();
        i_cha_scl = 1'b1; step();
        i_cha_sda = 1'b0; step();
        chk({tag, "_busy"}, o_busy, 1);
        chk({tag, "_en"}, o_chb_en, exp_en);
        chk({tag, "_bcnt"}, o_byte_cnt, 0);
        chk({tag, "_ackf"}, o_ack_failed, 0);
        chk({tag, "_rmode"}, o_read_mode, 0);
        chk({tag, "_dir"}, o_tx_to_mst, 0);
        i_cha_scl = 1'b0; step();
    endtask

    // STOP on channel A with both done inputs high in the same cycle.
    task automatic bus_stop(input string tag);
        i_cha_scl = 1'b0; i_cha_sda = 1'b0; step();
        i_cha_scl = 1'b1; step();
        chk({tag, "_busy_pre"}, o_busy, 1);
        i_cha_sda = 1'b1; i_rx_done = 1'b1; i_tx_done = 1'b1; step();
        chk({tag, "_nostart"}, o_start, 0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_en"}, o_chb_en, 0);
        i_rx_done = 1'b0; i_tx_done = 1'b0; step();
    endtask

    // One bit: handshake done, check launch and direction, then report sampled SDA.
    task automatic do_bit(input logic v, input logic exp_tx, input string tag);
        i_rx_done = 1'b1; i_tx_done = 1'b1; step();
        chk({tag, "_go"}, o_start, 1);
        chk({tag, "_dir"}, o_tx_to_mst, exp_tx);
        i_rx_done = 1'b0; i_tx_done = 1'b0; step();
        i_rx_sda_init_valid = 1'b1; i_rx_sda_init = v; step();
        i_rx_sda_init_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_tx, input string tag);
        for (int i = 7; i >= 0; i--) do_bit(b[i], exp_tx, tag);
    endtask

    initial begin
        step(); step();
        chk("rst_outs", {o_start, o_tx_to_mst, o_chb_en, o_busy, o_read_mode,
                         o_ack_failed, o_byte_cnt, o_timeout}, 0);
        i_rstn = 1'b1;
        step();
        chk("idle_busy", o_busy, 0);

        // Write to 0x50 on bus 1, one data byte.
        i_slv_sel = 1'b1;
        bus_start(2'b10, "wr");
        send_byte(8'hA0, 0, "wr_addr");
        do_bit(0, 1, "wr_aack");
        send_byte(8'hA5, 0, "wr_data");
        do_bit(0, 1, "wr_dack");
        do_bit(1, 0, "wr_next");
        chk("wr_bcnt", o_byte_cnt, 2);
        chk("wr_rmode", o_read_mode, 0);
        chk("wr_ackf", o_ack_failed, 0);
        bus_stop("wr_stop");
        chk("wr_bcnt_hold", o_byte_cnt, 2);

        // Read from 0x28 on bus 0: master ACK then NACK.
        i_slv_sel = 1'b0;
        bus_start(2'b01, "rd");
        send_byte(8'h51, 0, "rd_addr");
        chk("rd_rmode", o_read_mode, 1);
        do_bit(0, 1, "rd_aack");
        send_byte(8'h3C, 1, "rd_d0");
        do_bit(0, 0, "rd_mack");
        chk("rd_ackf0", o_ack_failed, 0);
        chk("rd_rmode_keep", o_read_mode, 1);
        send_byte(8'hC3, 1, "rd_d1");
        do_bit(1, 0, "rd_mnack");
        chk("rd_ackf1", o_ack_failed, 1);
        chk("rd_bcnt2", o_byte_cnt, 2);
        do_bit(1, 0, "rd_after");
        chk("rd_bcnt3", o_byte_cnt, 3);
        bus_stop("rd_stop");
        chk("rd_rmode_hold", o_read_mode, 1);
        chk("rd_ackf_hold", o_ack_failed, 1);
        chk("rd_bcnt_hold", o_byte_cnt, 3);

        // Address NACK, then a few bits stay master-driven until repeated START.
        bus_start(2'b01, "nk");
        send_byte(8'hA0, 0, "nk_addr");
        do_bit(1, 1, "nk_aack");
        chk("nk_ackf", o_ack_failed, 1);
        for (int i = 0; i < 4; i++) do_bit(0, 0, "nk_post");
        bus_start(2'b01, "nk_rs");

        // Repeated START mid-byte with a bus switch.
        send_byte(8'hA0, 0, "rs_addr");
        do_bit(0, 1, "rs_aack");
        for (int i = 0; i < 5; i++) do_bit(1, 0, "rs_mid");
        chk("rs_bcnt_pre", o_byte_cnt, 1);
        chk("rs_en_pre", o_chb_en, 2'b01);
        i_slv_sel = 1'b1;
        bus_start(2'b10, "rs2");
        chk("rs2_nostart", o_start, 0);
        send_byte(8'hA0, 0, "rs2_addr");
        do_bit(0, 1, "rs2_aack");
        chk("rs2_bcnt", o_byte_cnt, 0);

        // Stall: WAIT entered inside do_bit, timeout 20 edges after entry.
        do_bit(0, 0, "to_b1");
        for (int i = 0; i < 18; i++) begin
            step();
            chk("to_quiet", o_timeout, 0);
        end
        chk("to_busy_pre", o_busy, 1);
        step();
        chk("to_pulse", o_timeout, 1);
        chk("to_busy", o_busy, 0);
        chk("to_en", o_chb_en, 0);
        step();
        chk("to_pulse_end", o_timeout, 0);
        i_rx_done = 1'b1; i_tx_done = 1'b1; step();
        chk("to_idle_nostart", o_start, 0);
        i_rx_done = 1'b0; i_tx_done = 1'b0;

        // Asynchronous reset mid-byte, during a launch pulse.
        bus_start(2'b10, "rr");
        for (int i = 0; i < 4; i++) do_bit(0, 0, "rr_b");
        i_rx_done = 1'b1; i_tx_done = 1'b1; step();
        chk("rr_go", o_start, 1);
        #2 i_rstn = 1'b0;
        #1;
        chk("rr_outs", {o_start, o_tx_to_mst, o_chb_en, o_busy, o_read_mode,
                        o_ack_failed, o_byte_cnt, o_timeout}, 0);
        #2 i_rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rr_nostart", o_start, 0);
            chk("rr_idle", o_busy, 0);
        end
        i_rx_done = 1'b0; i_tx_done = 1'b0;
        bus_start(2'b10, "rr2");
        do_bit(1, 0, "rr2_b1");
        bus_stop("rr2_stop");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
